keypad_operand_entry: RTL and testbench
=======================================

Name: keypad_operand_entry

Overview:
- Sits directly downstream of the 4x4 keypad scanner and consumes its registered row/col/valid outputs.
- The scanner re-pulses valid roughly once per full row sweep while a key is held. This block turns those pulses into exactly one key event per physical press.
- It maps each key to a code and accumulates decimal digits into two BCD operands, A then B.
- It presents both operands to the arithmetic/display stage with a valid/ready handshake.

Parameters:
- NUM_DIGITS, 3, BCD digits per operand (range 1..4).
- RELEASE_CYCLES, 400_000, number of consecutive cycles with key_valid low after which a held key counts as released. Must exceed 4x the scanner's row period.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- key_valid  input  1  scanner strobe, one cycle wide
- key_row  input  2  scanner row index, qualified by key_valid
- key_col  input  2  scanner column index, qualified by key_valid
- operand_a  output  4*NUM_DIGITS  committed operand A, BCD, least-significant digit in bits [3:0]
- operand_b  output  4*NUM_DIGITS  committed operand B, BCD
- ops_valid  output  1  operand_a/operand_b pair is available
- ops_ready  input  1  consumer accepts the pair
- entry_bcd  output  4*NUM_DIGITS  digits currently being typed, for live display
- entry_count  output  3  number of digits in entry_bcd
- phase_b  output  1  0 = entering A, 1 = entering B

Behaviour:
- Key map, row/col → key:
  - (0,0..3) = 1 2 3 A
  - (1,0..3) = 4 5 6 B
  - (2,0..3) = 7 8 9 C
  - (3,0..3) = * 0 # D
- Press filter, states FREE and HELD:
  - In FREE, key_valid high produces a one-cycle internal key_strobe with the decoded code. The filter moves to HELD on the same edge.
  - In HELD, further key_valid pulses are ignored, including pulses carrying a different code. A release counter restarts to 0 on every key_valid.
  - The filter returns to FREE when the counter reaches RELEASE_CYCLES-1.
- Main FSM: ENTER_A → ENTER_B → PRESENT → ENTER_A.
- Digit key in ENTER_A or ENTER_B:
  - If entry_count < NUM_DIGITS: entry_bcd <= {entry_bcd shifted left one digit, digit}, entry_count + 1.
  - If entry_count == NUM_DIGITS, the digit is dropped (saturate, no wrap).
  - Leading zeros are counted as digits.
- '#':
  - If entry_count == 0, ignored.
  - Otherwise it copies entry_bcd into operand_a (ENTER_A) or operand_b (ENTER_B) and clears the entry.
  - ENTER_B → PRESENT, and ops_valid goes high on the next edge.
- '*': clears entry_bcd and entry_count only; phase is unchanged.
- 'D': clears the entry and both operands and returns to ENTER_A from any state, including PRESENT. It has priority over a handshake completing in the same cycle.
- 'A', 'B', 'C': ignored (see Optional Feature for 'C').
- PRESENT:
  - ops_valid is held high; operand_a and operand_b are stable; all keys except 'D' are ignored.
  - When ops_valid && ops_ready at an edge: ops_valid drops on that edge, state returns to ENTER_A, and phase_b is 0.
  - The operand registers keep their values until the next commit.
- Latency: key_valid at edge N produces the entry/operand update visible after edge N+1 (one cycle for the filter, one for the FSM).
- Reset, asserted asynchronously at any time including mid-entry or in PRESENT:
  - All outputs 0.
  - State ENTER_A.
  - Filter in FREE, release counter 0.

Optional Feature:
- Macro: KEYPAD_BACKSPACE_EN.
- Defined: in ENTER_A or ENTER_B, 'C' deletes the last typed digit. entry_bcd shifts right one digit with zero fill and entry_count decrements. With entry_count == 0 it does nothing.
- Undefined: 'C' is ignored like 'A' and 'B'; no backspace logic is synthesised.

Decomposition:
- Package keypad_pkg holds:
  - key_code_e enum: KEY_0..KEY_9, KEY_A..KEY_D, KEY_STAR, KEY_HASH.
  - entry_state_e enum: ENTER_A, ENTER_B, PRESENT.
  - A function decode_key(row, col) returning key_code_e.
  - A function is_digit(key_code_e).
- One sub-module, keypad_press_filter, contains the FREE/HELD filter, the release counter and decode_key. Its outputs are key_strobe and key_code.

Test Plan:
- Key "5" held for 10 scanner pulses spaced 100 cycles apart, with RELEASE_CYCLES=1000 → exactly one digit accepted; entry_bcd=0x005, entry_count=1.
- Press 1,2,3,4 with a release between each, then '#' → entry_bcd saturates at 0x123 (4 dropped); operand_a=0x123; phase_b=1; entry cleared.
- A=0x042 then B=0x007 committed, with ops_ready held 0 for 20 cycles → ops_valid stays 1 and operands stable; ops_ready=1 for one cycle → ops_valid=0 next cycle, phase_b=0.
- '#' with entry_count=0 → no state change. '*' after typing 9 → entry_count=0 with phase unchanged.
- In PRESENT, 'D' and ops_ready in the same cycle → state ENTER_A with operand_a=0 and operand_b=0.
- rst pulsed mid-entry (entry_count=2, filter in HELD) → all outputs 0 immediately. The next key_valid after rst deasserts is accepted.
- With KEYPAD_BACKSPACE_EN defined: type 7,8 then 'C' → entry_bcd=0x007, entry_count=1. Without the macro: unchanged at 0x078.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared key codes, entry-FSM states and keypad decode helpers for the operand entry block.
package keypad_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned CODE_W  = 4;

    // Digit keys encode as their own BCD value so a digit code can be shifted in directly.
    typedef enum logic [CODE_W-1:0] {
        KEY_0    = 4'd0,
        KEY_1    = 4'd1,
        KEY_2    = 4'd2,
        KEY_3    = 4'd3,
        KEY_4    = 4'd4,
        KEY_5    = 4'd5,
        KEY_6    = 4'd6,
        KEY_7    = 4'd7,
        KEY_8    = 4'd8,
        KEY_9    = 4'd9,
        KEY_A    = 4'd10,
        KEY_B    = 4'd11,
        KEY_C    = 4'd12,
        KEY_D    = 4'd13,
        KEY_STAR = 4'd14,
        KEY_HASH = 4'd15
    } key_code_e;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        PRESENT = 2'd2
    } entry_state_e;

    function automatic key_code_e decode_key(input logic [1:0] row, input logic [1:0] col);
        key_code_e key;
        case ({row, col})
            4'h0:    key = KEY_1;
            4'h1:    key = KEY_2;
            4'h2:    key = KEY_3;
            4'h3:    key = KEY_A;
            4'h4:    key = KEY_4;
            4'h5:    key = KEY_5;
            4'h6:    key = KEY_6;
            4'h7:    key = KEY_B;
            4'h8:    key = KEY_7;
            4'h9:    key = KEY_8;
            4'hA:    key = KEY_9;
            4'hB:    key = KEY_C;
            4'hC:    key = KEY_STAR;
            4'hD:    key = KEY_0;
            4'hE:    key = KEY_HASH;
            default: key = KEY_D;
        endcase
        return key;
    endfunction

    function automatic logic is_digit(input key_code_e key);
        return (CODE_W'(key) <= CODE_W'(KEY_9));
    endfunction

endpackage

// File: rtl/keypad_press_filter.sv
// Collapses the scanner's repeated valid pulses for a held key into a single decoded key strobe.
module keypad_press_filter
    import keypad_pkg::*;
#(
    parameter int unsigned RELEASE_CYCLES = 400_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid_i,
    input  logic [1:0]          key_row_i,
    input  logic [1:0]          key_col_i,
    output logic                key_strobe_o,
    output logic [CODE_W-1:0]   key_code_o
);

    localparam int unsigned CNT_W = (RELEASE_CYCLES > 2) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RELEASE_CYCLES - 1);

    typedef enum logic {
        FREE = 1'b0,
        HELD = 1'b1
    } filt_state_e;

    filt_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                strobe_q, strobe_d;
    logic [CODE_W-1:0]   code_q, code_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            code_q   <= code_d;
        end
    end

    // Any pulse while held, even for another key, restarts the release timer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        code_d   = code_q;
        case (state_q)
            FREE: begin
                if (key_valid_i) begin
                    strobe_d = 1'b1;
                    code_d   = CODE_W'(decode_key(key_row_i, key_col_i));
                    state_d  = HELD;
                    cnt_d    = '0;
                end
            end
            HELD: begin
                if (key_valid_i) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FREE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = FREE;
                cnt_d   = '0;
            end
        endcase
    end

    assign key_strobe_o = strobe_q;
    assign key_code_o   = code_q;

endmodule

// File: rtl/keypad_operand_entry.sv
// Keypad operand entry: accumulates BCD operands A and B from filtered key presses and hands them off.
// Optional backspace on 'C' is built when KEYPAD_BACKSPACE_EN is defined.
module keypad_operand_entry
    import keypad_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 3,
    parameter int unsigned RELEASE_CYCLES = 400_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_valid,
    input  logic [1:0]                  key_row,
    input  logic [1:0]                  key_col,
    output logic [4*NUM_DIGITS-1:0]     operand_a,
    output logic [4*NUM_DIGITS-1:0]     operand_b,
    output logic                        ops_valid,
    input  logic                        ops_ready,
    output logic [4*NUM_DIGITS-1:0]     entry_bcd,
    output logic [2:0]                  entry_count,
    output logic                        phase_b
);

    localparam int unsigned ENTRY_W   = DIGIT_W * NUM_DIGITS;
    localparam logic [2:0]  MAX_COUNT = 3'(NUM_DIGITS);

    logic                   key_strobe;
    logic [CODE_W-1:0]      key_code;
    key_code_e              key_e;

    entry_state_e           state_q, state_d;
    logic [ENTRY_W-1:0]     entry_q, entry_d;
    logic [2:0]             count_q, count_d;
    logic [ENTRY_W-1:0]     op_a_q, op_a_d;
    logic [ENTRY_W-1:0]     op_b_q, op_b_d;
    logic                   ops_valid_q, ops_valid_d;
    logic                   phase_b_q, phase_b_d;

    keypad_press_filter #(
        .RELEASE_CYCLES (RELEASE_CYCLES)
    ) u_filter (
        .clk          (clk),
        .rst          (rst),
        .key_valid_i  (key_valid),
        .key_row_i    (key_row),
        .key_col_i    (key_col),
        .key_strobe_o (key_strobe),
        .key_code_o   (key_code)
    );

    assign key_e = key_code_e'(key_code);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ENTER_A;
            entry_q     <= '0;
            count_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            ops_valid_q <= 1'b0;
            phase_b_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            count_q     <= count_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            ops_valid_q <= ops_valid_d;
            phase_b_q   <= phase_b_d;
        end
    end

    // 'D' wins over everything, including a handshake completing on the same edge.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        count_d = count_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;

        if (key_strobe && (key_e == KEY_D)) begin
            state_d = ENTER_A;
            entry_d = '0;
            count_d = '0;
            op_a_d  = '0;
            op_b_d  = '0;
        end else if (state_q == PRESENT) begin
            if (ops_valid_q && ops_ready) begin
                state_d = ENTER_A;
            end
        end else if (key_strobe) begin
            if (is_digit(key_e)) begin
                if (count_q < MAX_COUNT) begin
                    entry_d = (entry_q << DIGIT_W) | ENTRY_W'(key_code);
                    count_d = count_q + 3'd1;
                end
            end else if (key_e == KEY_HASH) begin
                if (count_q != 3'd0) begin
                    if (state_q == ENTER_A) begin
                        op_a_d  = entry_q;
                        state_d = ENTER_B;
                    end else begin
                        op_b_d  = entry_q;
                        state_d = PRESENT;
                    end
                    entry_d = '0;
                    count_d = '0;
                end
            end else if (key_e == KEY_STAR) begin
                entry_d = '0;
                count_d = '0;
`ifdef KEYPAD_BACKSPACE_EN
            end else if (key_e == KEY_C) begin
                if (count_q != 3'd0) begin
                    entry_d = entry_q >> DIGIT_W;
                    count_d = count_q - 3'd1;
                end
`endif
            end
        end

        ops_valid_d = (state_d == PRESENT);
        phase_b_d   = (state_d != ENTER_A);
    end

    assign operand_a   = op_a_q;
    assign operand_b   = op_b_q;
    assign ops_valid   = ops_valid_q;
    assign entry_bcd   = entry_q;
    assign entry_count = count_q;
    assign phase_b     = phase_b_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Scoreboard bench for keypad_operand_entry: a digit-list reference model queues expected state,
// monitors compare it after each scanner pulse and on every operand handshake.
module tb_keypad_operand_entry;

    localparam int ND     = 3;
    localparam int RC     = 200;
    localparam int GAP    = 40;
    localparam int K_A    = 10;
    localparam int K_C    = 12;
    localparam int K_D    = 13;
    localparam int K_STAR = 14;
    localparam int K_HASH = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [1:0]  key_row = 2'd0;
    logic [1:0]  key_col = 2'd0;
    logic        ops_ready = 1'b0;
    logic [11:0] operand_a, operand_b, entry_bcd;
    logic        ops_valid, phase_b;
    logic [2:0]  entry_count;

    keypad_operand_entry #(
        .NUM_DIGITS     (ND),
        .RELEASE_CYCLES (RC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_row     (key_row),
        .key_col     (key_col),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .ops_valid   (ops_valid),
        .ops_ready   (ops_ready),
        .entry_bcd   (entry_bcd),
        .entry_count (entry_count),
        .phase_b     (phase_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] ent;
        int          cnt;
        logic        ph;
        logic        v;
        logic [11:0] a;
        logic [11:0] b;
        int          lat;
    } snap_t;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
    } pair_t;

    snap_t exp_q[$];
    pair_t pair_q[$];
    event  chk_ev;

    int tests = 0;
    int errors = 0;

    // Keypad layout, index row*4+col; 10..13 = A..D, 14 = '*', 15 = '#'.
    int keymap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    int          m_dig[$];
    int          m_phase = 0;
    logic [11:0] m_a = '0;
    logic [11:0] m_b = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [11:0] bcd_of();
        int v = 0;
        foreach (m_dig[i]) v = v * 16 + m_dig[i];
        return 12'(v);
    endfunction

    function automatic snap_t mk(input int lat);
        snap_t s;
        s.ent = bcd_of();
        s.cnt = m_dig.size();
        s.ph  = (m_phase != 0);
        s.v   = (m_phase == 2);
        s.a   = m_a;
        s.b   = m_b;
        s.lat = lat;
        return s;
    endfunction

    function automatic void m_reset();
        m_dig.delete();
        m_phase = 0;
        m_a = '0;
        m_b = '0;
        pair_q.delete();
    endfunction

    function automatic void m_apply(input int key);
        if (key == K_D) begin
            if (m_phase == 2) pair_q.delete();
            m_dig.delete();
            m_a = '0;
            m_b = '0;
            m_phase = 0;
        end else if (m_phase == 2) begin
            m_phase = 2;
        end else if (key <= 9) begin
            if (m_dig.size() < ND) m_dig.push_back(key);
        end else if (key == K_HASH) begin
            if (m_dig.size() > 0) begin
                if (m_phase == 0) begin
                    m_a = bcd_of();
                    m_phase = 1;
                end else begin
                    m_b = bcd_of();
                    m_phase = 2;
                    pair_q.push_back('{m_a, m_b});
                end
                m_dig.delete();
            end
        end else if (key == K_STAR) begin
            m_dig.delete();
`ifdef KEYPAD_BACKSPACE_EN
        end else if (key == K_C) begin
            if (m_dig.size() > 0) void'(m_dig.pop_back());
`endif
        end
    endfunction

    task automatic find_rc(input int key, output logic [1:0] r, output logic [1:0] c);
        r = 2'd0;
        c = 2'd0;
        for (int i = 0; i < 16; i++)
            if (keymap[i] == key) begin
                r = 2'(i / 4);
                c = 2'(i % 4);
            end
    endtask

    // One physical press: several scanner pulses, later ones possibly carrying other codes.
    task automatic press(input int key, input int pulses);
        logic [1:0] r, c;
        find_rc(key, r, c);
        for (int p = 0; p < pulses; p++) begin
            @(posedge clk); #1;
            key_valid = 1'b1;
            if (p == 0 || $urandom_range(0, 1) == 0) begin
                key_row = r;
                key_col = c;
            end else begin
                key_row = 2'($urandom_range(0, 3));
                key_col = 2'($urandom_range(0, 3));
            end
            if (p == 0) m_apply(key);
            exp_q.push_back(mk(2));
            -> chk_ev;
            @(posedge clk); #1;
            key_valid = 1'b0;
            repeat (GAP - 2) @(posedge clk);
        end
        repeat (RC + 10) @(posedge clk);
    endtask

    task automatic handshake();
        @(posedge clk); #1;
        ops_ready = 1'b1;
        if (m_phase == 2) m_phase = 0;
        exp_q.push_back(mk(1));
        -> chk_ev;
        @(posedge clk); #1;
        ops_ready = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic type_keys(input int keys[$]);
        foreach (keys[i]) press(keys[i], $urandom_range(1, 3));
    endtask

    // State monitor: compares the queued expectation once the press has propagated.
    initial begin
        snap_t s;
        forever begin
            @(chk_ev);
            if (exp_q.size() == 0) begin
                chk("exp_q_underflow", 32'd1, 32'd0);
            end else begin
                s = exp_q.pop_front();
                repeat (s.lat) @(posedge clk);
                @(negedge clk);
                chk("entry_bcd", 32'(entry_bcd), 32'(s.ent));
                chk("entry_count", 32'(entry_count), 32'(s.cnt));
                chk("phase_b", 32'(phase_b), 32'(s.ph));
                chk("ops_valid", 32'(ops_valid), 32'(s.v));
                chk("operand_a", 32'(operand_a), 32'(s.a));
                chk("operand_b", 32'(operand_b), 32'(s.b));
            end
        end
    end

    // Handshake monitor: every accepted pair must match the next committed pair.
    initial begin
        pair_t p;
        forever begin
            @(negedge clk);
            if (!rst && ops_valid && ops_ready) begin
                if (pair_q.size() == 0) begin
                    chk("unexpected_handshake", 32'd1, 32'd0);
                end else begin
                    p = pair_q.pop_front();
                    chk("hs_operand_a", 32'(operand_a), 32'(p.a));
                    chk("hs_operand_b", 32'(operand_b), 32'(p.b));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] r, c;
        pair_t      saved[$];
        int         k, sel;

        #1 rst = 1'b1;
        #1;
        chk("rst_entry_bcd", 32'(entry_bcd), 32'd0);
        chk("rst_entry_count", 32'(entry_count), 32'd0);
        chk("rst_ops_valid", 32'(ops_valid), 32'd0);
        chk("rst_phase_b", 32'(phase_b), 32'd0);
        chk("rst_operand_a", 32'(operand_a), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Held key yields exactly one digit.
        press(5, 10);
        chk("held5_entry", 32'(entry_bcd), 32'h005);
        chk("held5_count", 32'(entry_count), 32'd1);
        press(K_STAR, 1);

        // Saturation then commit of A.
        type_keys('{1, 2, 3, 4});
        chk("sat_entry", 32'(entry_bcd), 32'h123);
        press(K_HASH, 2);
        chk("commit_a", 32'(operand_a), 32'h123);
        chk("commit_a_phase", 32'(phase_b), 32'd1);

        // '#' on an empty entry, then '*' clears without changing phase.
        press(K_HASH, 1);
        press(9, 2);
        press(K_STAR, 1);
        chk("star_phase", 32'(phase_b), 32'd1);
        press(K_D, 1);

        // Full A/B commit with a stalled consumer.
        type_keys('{0, 4, 2, K_HASH, 0, 0, 7, K_HASH});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(ops_valid), 32'd1);
            chk("stall_a", 32'(operand_a), 32'h042);
            chk("stall_b", 32'(operand_b), 32'h007);
        end
        handshake();
        chk("post_hs_phase", 32'(phase_b), 32'd0);

        // 'D' arriving on the same edge as the handshake.
        type_keys('{1, K_HASH, 2, K_HASH});
        find_rc(K_D, r, c);
        @(posedge clk); #1;
        key_valid = 1'b1;
        key_row = r;
        key_col = c;
        saved = pair_q;
        m_apply(K_D);
        pair_q = saved;
        exp_q.push_back(mk(2));
        -> chk_ev;
        @(posedge clk); #1;
        key_valid = 1'b0;
        ops_ready = 1'b1;
        @(posedge clk); #1;
        ops_ready = 1'b0;
        repeat (RC + 10) @(posedge clk);
        chk("dready_a", 32'(operand_a), 32'd0);
        chk("dready_b", 32'(operand_b), 32'd0);

        // Reset while a key is held mid-entry.
        press(1, 1);
        find_rc(2, r, c);
        @(posedge clk); #1;
        key_valid = 1'b1;
        key_row = r;
        key_col = c;
        m_apply(2);
        exp_q.push_back(mk(2));
        -> chk_ev;
        @(posedge clk); #1;
        key_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_entry", 32'(entry_bcd), 32'd0);
        chk("mid_rst_count", 32'(entry_count), 32'd0);
        chk("mid_rst_a", 32'(operand_a), 32'd0);
        chk("mid_rst_phase", 32'(phase_b), 32'd0);
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        press(8, 1);
        chk("after_rst_entry", 32'(entry_bcd), 32'h008);

        // 'C' behaviour depends on the build option.
        press(K_D, 1);
        type_keys('{7, 8, K_C});
`ifdef KEYPAD_BACKSPACE_EN
        chk("bksp_entry", 32'(entry_bcd), 32'h007);
        chk("bksp_count", 32'(entry_count), 32'd1);
`else
        chk("bksp_entry", 32'(entry_bcd), 32'h078);
        chk("bksp_count", 32'(entry_count), 32'd2);
`endif

        // Randomized key stream against the model.
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 15);
            if (sel < 9)       k = $urandom_range(0, 9);
            else if (sel < 13) k = K_HASH;
            else if (sel == 13) k = K_STAR;
            else if (sel == 14) k = K_A + $urandom_range(0, 2);
            else               k = K_D;
            press(k, $urandom_range(1, 3));
            if (m_phase == 2 && $urandom_range(0, 1) == 1) handshake();
        end
        if (m_phase == 2) handshake();

        repeat (5) @(posedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("pair_q_drained", 32'(pair_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
